// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, REQ/HOLD fetch FSM, stall hold buffer, branch redirect.
// Define IF_JUMP_EN to compile in J-type jump redirects from ID.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        PCSrc_ID,
    input  logic [31:0] BranchTarget_ID,
    input  logic        Jump_ID,
    input  logic [25:0] JumpAddr_ID,
    input  logic [31:0] PCplus4_ID,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCplus4_IF,
    output logic [31:0] Instr_IF,
    output logic        fetch_valid
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [31:0] w_pc_n;
    logic [31:0] w_buf_n;
    logic [31:0] w_pc4;
    logic [31:0] w_raw_target;
    logic [31:0] w_target;
    logic        w_redirect;
    logic        w_req;
    logic        w_valid;
    logic [31:0] w_instr;

`ifdef IF_JUMP_EN
    logic [31:0] w_jump_target;
    logic        w_unused_bits;

    assign w_jump_target = {PCplus4_ID[31:28], JumpAddr_ID, 2'b00};
    assign w_redirect    = ~stall & (PCSrc_ID | Jump_ID);
    assign w_raw_target  = PCSrc_ID ? BranchTarget_ID : w_jump_target;
    assign w_unused_bits = ^{PCplus4_ID[27:0], w_raw_target[1:0]};
`else
    logic w_unused_bits;

    assign w_redirect    = ~stall & PCSrc_ID;
    assign w_raw_target  = BranchTarget_ID;
    assign w_unused_bits = ^{Jump_ID, JumpAddr_ID, PCplus4_ID,
                             w_raw_target[1:0]};
`endif

    assign w_target = {w_raw_target[31:2], 2'b00};
    assign w_pc4    = r_pc + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_REQ;
            r_pc    <= 32'h0;
            r_buf   <= 32'h0;
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_buf   <= w_buf_n;
        end
    end

    // A redirect squashes whatever this stage would present and restarts in REQ
    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_buf_n   = r_buf;
        w_req     = 1'b0;
        w_instr   = 32'h0;
        w_valid   = 1'b0;
        if (w_redirect) begin
            w_req     = (r_state == S_REQ);
            w_pc_n    = w_target;
            w_state_n = S_REQ;
        end else begin
            unique case (r_state)
                S_REQ: begin
                    w_req = 1'b1;
                    if (imem_ack) begin
                        w_instr = imem_rdata;
                        w_valid = 1'b1;
                        if (stall) begin
                            w_buf_n   = imem_rdata;
                            w_state_n = S_HOLD;
                        end else begin
                            w_pc_n = w_pc4;
                        end
                    end
                end
                S_HOLD: begin
                    w_instr = r_buf;
                    w_valid = 1'b1;
                    if (!stall) begin
                        w_pc_n    = w_pc4;
                        w_state_n = S_REQ;
                    end
                end
                default: begin
                    w_state_n = S_REQ;
                end
            endcase
        end
    end

    assign imem_req    = w_req & ~reset;
    assign imem_addr   = r_pc;
    assign PCplus4_IF  = w_pc4;
    assign Instr_IF    = reset ? 32'h0 : w_instr;
    assign fetch_valid = w_valid & ~reset;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; per-cycle expectations go through a scoreboard queue.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        PCSrc_ID;
    logic [31:0] BranchTarget_ID;
    logic        Jump_ID;
    logic [25:0] JumpAddr_ID;
    logic [31:0] PCplus4_ID;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PCplus4_IF;
    logic [31:0] Instr_IF;
    logic        fetch_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       nm;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        vld;
        logic [31:0] pc4;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .PCSrc_ID       (PCSrc_ID),
        .BranchTarget_ID(BranchTarget_ID),
        .Jump_ID        (Jump_ID),
        .JumpAddr_ID    (JumpAddr_ID),
        .PCplus4_ID     (PCplus4_ID),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .PCplus4_IF     (PCplus4_IF),
        .Instr_IF       (Instr_IF),
        .fetch_valid    (fetch_valid)
    );

    task automatic chk(string nm, string f,
                       logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got=%h want=%h", nm, f, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "req", {31'b0, imem_req}, {31'b0, e.req});
            chk(e.nm, "addr", imem_addr, e.addr);
            chk(e.nm, "instr", Instr_IF, e.instr);
            chk(e.nm, "valid", {31'b0, fetch_valid}, {31'b0, e.vld});
            chk(e.nm, "pc4", PCplus4_IF, e.pc4);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(string nm, logic rq, logic [31:0] a,
                              logic [31:0] ins, logic v);
        exp_t e;
        e.nm    = nm;
        e.req   = rq;
        e.addr  = a;
        e.instr = ins;
        e.vld   = v;
        e.pc4   = a + 32'd4;
        q.push_back(e);
    endtask

    // Acked fetch with stall low at the given PC
    task automatic fetch(string nm, logic [31:0] a, logic [31:0] d);
        step();
        imem_ack   = 1'b1;
        imem_rdata = d;
        stall      = 1'b0;
        expect_out(nm, 1'b1, a, d, 1'b1);
    endtask

    logic [31:0] jpc;

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        PCSrc_ID        = 1'b0;
        BranchTarget_ID = 32'h0;
        Jump_ID         = 1'b0;
        JumpAddr_ID     = 26'h0;
        PCplus4_ID      = 32'h0;
        imem_ack        = 1'b0;
        imem_rdata      = 32'h0;

        step();
        imem_ack = 1'b1;
        expect_out("rst", 1'b0, 32'h0, 32'h0, 1'b0);

        step();
        reset      = 1'b0;
        imem_rdata = 32'h11111111;
        expect_out("seq0", 1'b1, 32'h0, 32'h11111111, 1'b1);
        fetch("seq4", 32'h4, 32'h12121212);
        fetch("seq8", 32'h8, 32'h13131313);
        fetch("seqC", 32'hC, 32'h14141414);

        for (int i = 0; i < 3; i++) begin
            step();
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEADBEEF;
            expect_out("noack", 1'b1, 32'h10, 32'h0, 1'b0);
        end
        fetch("ack10", 32'h10, 32'hA5A5A5A5);

        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'h8C220004;
        stall      = 1'b1;
        expect_out("stall_ack", 1'b1, 32'h14, 32'h8C220004, 1'b1);
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        expect_out("hold1", 1'b0, 32'h14, 32'h8C220004, 1'b1);
        step();
        stall = 1'b0;
        expect_out("hold_rel", 1'b0, 32'h14, 32'h8C220004, 1'b1);

        step();
        imem_ack        = 1'b1;
        imem_rdata      = 32'h22222222;
        PCSrc_ID        = 1'b1;
        BranchTarget_ID = 32'h00000043;
        expect_out("br_squash", 1'b1, 32'h18, 32'h0, 1'b0);
        step();
        PCSrc_ID = 1'b0;
        imem_rdata = 32'h33333333;
        expect_out("br_tgt", 1'b1, 32'h40, 32'h33333333, 1'b1);

        step();
        imem_ack = 1'b0;
        PCSrc_ID = 1'b1;
        stall    = 1'b1;
        expect_out("br_stalled", 1'b1, 32'h44, 32'h0, 1'b0);
        step();
        PCSrc_ID = 1'b0;
        fetch("after_stbr", 32'h44, 32'h44444444);

        step();
        imem_ack    = 1'b1;
        imem_rdata  = 32'h55555555;
        Jump_ID     = 1'b1;
        JumpAddr_ID = 26'h0000100;
        PCplus4_ID  = 32'h30000008;
`ifdef IF_JUMP_EN
        jpc = 32'h30000400;
        expect_out("jmp", 1'b1, 32'h48, 32'h0, 1'b0);
`else
        jpc = 32'h0000004C;
        expect_out("jmp", 1'b1, 32'h48, 32'h55555555, 1'b1);
`endif
        step();
        Jump_ID = 1'b0;
        imem_rdata = 32'h66666666;
        expect_out("jmp_next", 1'b1, jpc, 32'h66666666, 1'b1);

        step();
        imem_ack        = 1'b0;
        PCSrc_ID        = 1'b1;
        BranchTarget_ID = 32'hFFFFFFFF;
        expect_out("br_noack", 1'b1, jpc + 32'd4, 32'h0, 1'b0);
        step();
        PCSrc_ID = 1'b0;
        fetch("wrap", 32'hFFFFFFFC, 32'h77777777);
        fetch("wrap0", 32'h0, 32'h78787878);

        step();
        imem_rdata = 32'h88888888;
        stall      = 1'b1;
        expect_out("st4", 1'b1, 32'h4, 32'h88888888, 1'b1);
        step();
        imem_ack = 1'b0;
        expect_out("hold4", 1'b0, 32'h4, 32'h88888888, 1'b1);
        step();
        reset = 1'b1;
        expect_out("rst_hold", 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        reset      = 1'b0;
        stall      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h99999999;
        expect_out("post_rst", 1'b1, 32'h0, 32'h99999999, 1'b1);
        fetch("post_rst4", 32'h4, 32'hABABABAB);

        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            step();
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset; one clock domain only.
REQ-003 stall  input  1  hazard-unit stall; the same signal drives the IF/ID register hold.
REQ-004 PCSrc_ID  input  1  branch taken, resolved in ID.
REQ-005 BranchTarget_ID  input  32  branch target from ID.
REQ-006 Jump_ID  input  1  J-type jump decoded in ID.
REQ-007 JumpAddr_ID  input  26  instr[25:0] of the jump.
REQ-008 PCplus4_ID  input  32  PC+4 of the instruction in ID.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  fetch address; always equals PC.
REQ-011 imem_ack  input  1  read data valid this cycle; meaningful only while imem_req=1.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 PCplus4_IF  output  32  PC+4 to IF/ID.
REQ-014 Instr_IF  output  32  instruction to IF/ID; 32'h0 (NOP) when no valid instruction.
REQ-015 fetch_valid  output  1  Instr_IF carries a real fetched instruction.

Function
REQ-016 The block shall hold a 32-bit PC register, a 32-bit hold buffer and a 2-state FSM: REQ and HOLD.
REQ-017 PCplus4_IF shall be PC+4 mod 2^32; PC 32'hFFFFFFFC shall wrap to 32'h00000000.
REQ-018 In REQ, imem_req shall be 1; without imem_ack: Instr_IF=0, fetch_valid=0, PC held.
REQ-019 In REQ with imem_ack and stall=0: Instr_IF=imem_rdata and fetch_valid=1 in the same cycle (zero-latency pass-through); PC<=next PC; remain in REQ.
REQ-020 In REQ with imem_ack and stall=1: buffer<=imem_rdata; PC held; go to HOLD.
REQ-021 In HOLD: imem_req=0; Instr_IF=buffer; fetch_valid=1; PC held while stall=1.
REQ-022 In HOLD with stall=0: PC<=next PC; go to REQ.
REQ-023 Next PC shall be, in priority order: redirect target, then PC+4.
REQ-024 A redirect shall occur when stall=0 and (PCSrc_ID=1, or Jump_ID=1 with IF_JUMP_EN defined).
REQ-025 Redirect targets: branch = BranchTarget_ID; jump = {PCplus4_ID[31:28], JumpAddr_ID, 2'b00}; PCSrc_ID wins if both are asserted.
REQ-026 Target bits [1:0] shall be forced to 0.
REQ-027 On redirect, in any state and regardless of imem_ack:
  - Instr_IF=0 and fetch_valid=0 that cycle (wrong-path instruction squashed);
  - PC<=target;
  - FSM<=REQ.
REQ-028 A redirect shall abort a pending REQ without ack; the memory shall tolerate an address change while unacknowledged.
REQ-029 With stall=1, PCSrc_ID and Jump_ID shall be ignored.

Reset
REQ-030 When reset=1, asynchronously and immediately: PC=0, buffer=0, FSM=REQ.
REQ-031 While reset=1: imem_req=0 (gated by reset), Instr_IF=0, fetch_valid=0, PCplus4_IF=32'h4.
REQ-032 Reset asserted mid-HOLD or mid-REQ shall discard all state; the first request after release shall use address 0.

Configuration
REQ-033 Macro IF_JUMP_EN:
  - Defined: jump redirect logic is compiled in.
  - Undefined: Jump_ID, JumpAddr_ID and PCplus4_ID are present but ignored, and only branches redirect.

Verification
REQ-034 Reset release with imem_ack tied to 1 and stall=0 -> imem_addr = 0, 4, 8 on successive cycles; fetch_valid=1 on each.
REQ-035 imem_ack low for 3 cycles at PC=0x10 -> Instr_IF=0 and fetch_valid=0 for 3 cycles; PC stays 0x10; on ack, Instr_IF=imem_rdata.
REQ-036 Ack with stall=1 for 2 cycles, rdata=0x8C220004 -> HOLD, Instr_IF=0x8C220004 for both cycles, imem_req=0; PC advances only after stall drops.
REQ-037 PCSrc_ID=1, BranchTarget_ID=0x00000043 -> squash cycle with Instr_IF=0; next imem_addr=0x40. With stall=1 simultaneously -> no redirect.
REQ-038 IF_JUMP_EN defined: Jump_ID=1, JumpAddr_ID=0x0000100, PCplus4_ID=0x30000008 -> next imem_addr=0x30000400. Undefined: next imem_addr=PC+4.
REQ-039 PC=0xFFFFFFFC with ack -> next PC=0. Async reset asserted mid-HOLD -> outputs reach reset values before the next clock edge.
